sh4_fpu_rsh_arb: RTL
====================

Name: sh4_fpu_rsh_arb

Overview:
- Shares one sticky-collecting right shifter between two FPU requesters.
- Requester A: FADD/FSUB exponent alignment. Requester B: FTRC/FCNV integer conversion.
- Round-robin arbitration, two-stage registered pipeline (operand stage S1, result stage S2), valid/ready backpressure, synchronous flush.
- Sits between the FPU issue logic and the rounding/normalise stages.

Parameters:
- WIDTH, 64, datapath width (double mantissa plus guard bits).
- SWIDTH, 7, shift amount width.
- TAGW, 3, opaque tag width returned with each result.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  drop all in-flight operations
- a_valid  in  1  requester A request valid
- a_ready  out  1  requester A accepted this cycle when a_valid&a_ready
- a_data  in  WIDTH  requester A operand
- a_shamt  in  SWIDTH  requester A shift amount
- a_tag  in  TAGW  requester A tag
- b_valid  in  1  requester B request valid
- b_ready  out  1  requester B accepted this cycle when b_valid&b_ready
- b_data  in  WIDTH  requester B operand
- b_shamt  in  SWIDTH  requester B shift amount
- b_tag  in  TAGW  requester B tag
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  WIDTH  shifted result with sticky LSB
- rsp_src  out  1  0 = A, 1 = B
- rsp_tag  out  TAGW  tag of the originating request

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n sampled on the clk rising edge).
- Reset values: S1/S2 valid = 0; rsp_valid = 0; rsp_data = 0; rsp_src = 0; rsp_tag = 0; last_grant = B, so A wins the first conflict.
- Pipeline advance: adv2 = !s2_valid | rsp_ready; adv1 = !s1_valid | adv2.
- Ready generation: a_ready and b_ready are combinational.
  - Both are 0 when adv1 = 0, flush = 1, or rst_n = 0.
  - Otherwise the grant is: only A valid -> A; only B valid -> B; both valid -> the source that is not last_grant.
  - The granted requester sees ready = 1. The other sees ready = 0.
  - With no valid requester, a_ready = 1 and b_ready = 0. Ready is grant-gated, never speculative for both.
- last_grant updates only on an actual accept.
- S1 latches data, shamt, tag and src on accept. S1 valid clears when S1 advances with no new accept.
- Shift function, computed between S1 and S2 and registered into S2:
  - shamt < WIDTH: result[WIDTH-1:1] = data[WIDTH-1:1] >> shamt (zero fill); result[0] = OR of data[shamt:0].
  - shamt >= WIDTH: result = 0 except result[0] = OR of all data bits.
  - shamt = 0: result = data exactly.
- S2 drives the rsp_* outputs directly from registers.
- Latency and throughput: accept in cycle N -> rsp_valid in cycle N+2 when unstalled. Throughput is 1 result per cycle.
- Stall: with rsp_ready = 0 and rsp_valid = 1, rsp_* hold stable. S1 holds if full; ready drops once S1 is also full. No result is lost or duplicated.
- Ordering: results are returned in acceptance order.
- flush: the following clk edge clears S1 and S2 valid. rsp_data/rsp_tag may hold stale values while rsp_valid = 0. No accept occurs in the flush cycle. last_grant is unchanged.
- rst_n low mid-operation: same as flush, plus last_grant and all rsp_* outputs return to their reset values.
- Simultaneous rsp handshake and new accept with both stages full: legal, the pipeline shifts by one.

Test Plan:
- Single A request:
  - Stimulus: data = 0x0000_0000_0000_00F0, shamt = 4, tag = 5.
  - Response: accepted at N; rsp_valid at N+2 with data 0x...0F, src = 0, tag = 5.
- Sticky collection:
  - shamt = 4, data = 0x...0001 -> rsp_data = 0x...0001.
  - shamt = 64, data = 0x8000_0000_0000_0000 -> rsp_data = 0x...0001.
  - shamt = 100, data = 0 -> rsp_data = 0.
- Arbitration: a_valid and b_valid held high for 4 cycles from reset, rsp_ready = 1 -> grants A, B, A, B; rsp_src sequence 0, 1, 0, 1 arriving back-to-back.
- Backpressure: fill with 3 A requests, rsp_ready = 0 for 5 cycles -> rsp_* stable, a_ready = 0 after 2 accepts; on release, results appear in order with no gap or loss.
- Flush: flush asserted with both stages full -> rsp_valid = 0 next cycle, flushed tags never appear, and a new request accepted afterwards returns normally.
- Reset: rst_n low for 1 cycle mid-stream -> all outputs at reset values; the next conflict is granted to A.

Source files
------------

// File: rtl/sh4_fpu_rsh_arb.sv
// Round-robin arbiter sharing one sticky-collecting right shifter between the
// FADD/FSUB alignment path (A) and the FTRC/FCNV conversion path (B).
module sh4_fpu_rsh_arb #(
  parameter int WIDTH  = 64,
  parameter int SWIDTH = 7,
  parameter int TAGW   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [WIDTH-1:0]  a_data,
  input  logic [SWIDTH-1:0] a_shamt,
  input  logic [TAGW-1:0]   a_tag,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [WIDTH-1:0]  b_data,
  input  logic [SWIDTH-1:0] b_shamt,
  input  logic [TAGW-1:0]   b_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_src,
  output logic [TAGW-1:0]   rsp_tag
);

  logic              r_last_grant;  // 1 = B was granted last
  logic              r_s1_valid;
  logic [WIDTH-1:0]  r_s1_data;
  logic [SWIDTH-1:0] r_s1_shamt;
  logic [TAGW-1:0]   r_s1_tag;
  logic              r_s1_src;
  logic              r_s2_valid;
  logic [WIDTH-1:0]  r_s2_data;
  logic              r_s2_src;
  logic [TAGW-1:0]   r_s2_tag;

  logic              w_adv2;
  logic              w_adv1;
  logic              w_open;
  logic              w_grant_b;
  logic              w_accept;
  logic [WIDTH-1:0]  w_shr;
  logic [WIDTH-1:0]  w_lost_mask;
  logic              w_sticky;
  logic [WIDTH-1:0]  w_result;

  assign w_adv2    = !r_s2_valid | rsp_ready;
  assign w_adv1    = !r_s1_valid | w_adv2;
  assign w_open    = w_adv1 & ~flush & rst_n;
  assign w_grant_b = b_valid & (~a_valid | ~r_last_grant);
  assign a_ready   = w_open & ~w_grant_b;
  assign b_ready   = w_open & w_grant_b;
  assign w_accept  = (a_valid & a_ready) | (b_valid & b_ready);

  // Bits below shamt are lost; data[shamt] lands in bit 0 of w_shr, so the
  // sticky covers data[shamt:0]. Shifts of WIDTH or more fold everything in.
  assign w_shr       = r_s1_data >> r_s1_shamt;
  assign w_lost_mask = ~({WIDTH{1'b1}} << r_s1_shamt);
  assign w_sticky    = (|(r_s1_data & w_lost_mask)) | w_shr[0];
  assign w_result    = {w_shr[WIDTH-1:1], w_sticky};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_grant_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= w_accept;
    end
    if (w_accept) begin
      r_s1_data  <= w_grant_b ? b_data  : a_data;
      r_s1_shamt <= w_grant_b ? b_shamt : a_shamt;
      r_s1_tag   <= w_grant_b ? b_tag   : a_tag;
      r_s1_src   <= w_grant_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_src   <= 1'b0;
      r_s2_tag   <= '0;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_result;
        r_s2_src  <= r_s1_src;
        r_s2_tag  <= r_s1_tag;
      end
    end
  end

  assign rsp_valid = r_s2_valid;
  assign rsp_data  = r_s2_data;
  assign rsp_src   = r_s2_src;
  assign rsp_tag   = r_s2_tag;

endmodule
